board_readback: RTL and testbench
=================================

// Module: board_readback
// PURPOSE
//  Read-side counterpart to the tile storage registers (Load/D writers).
//  - On Start, snapshots all NUM_TILES tile registers in a single cycle.
//  - Streams the snapshot out one tile per transfer, tile 0 first, over a valid/ready handshake.
//  - Accumulates the maximum tile value and the count of empty (zero) tiles.
//  - Sits between the board register bank and the consumers (score/draw/game-over logic).
// PARAMETERS
//  NUM_TILES  16  number of tile registers read per scan
//  DATA_W     12  width of each tile register
//  IDX_W       4  tile index width, equal to $clog2(NUM_TILES)
//  CNT_W       5  empty-count width, equal to $clog2(NUM_TILES+1)
// PORTS
//  Clk          in   1                 clock, all state updates on posedge
//  Reset        in   1                 synchronous, active-high
//  Start        in   1                 request a scan; sampled only in IDLE
//  Board_In     in   NUM_TILES*DATA_W  tile t occupies bits [t*DATA_W +: DATA_W]
//  Out_Ready    in   1                 consumer accepts Out_Data this cycle
//  Out_Valid    out  1                 Out_Data/Out_Index/Out_Last are valid
//  Out_Data     out  DATA_W            snapshot value of the current tile
//  Out_Index    out  IDX_W             index of the current tile
//  Out_Last     out  1                 current tile is NUM_TILES-1
//  Busy         out  1                 high in STREAM and DONE
//  Done         out  1                 one-cycle pulse after the last transfer
//  Max_Tile     out  DATA_W            largest value in the last completed scan
//  Empty_Count  out  CNT_W             number of zero tiles in the last completed scan
// BEHAVIOUR
//  - Reset (at any time, including mid-scan):
//    - FSM goes to IDLE.
//    - All outputs go to 0; the snapshot, index and accumulators are cleared.
//  - FSM states and transitions:
//    - IDLE -> STREAM when Start=1: capture Board_In into the shadow, index<=0, clear accumulators.
//    - STREAM -> DONE on the transfer where Out_Last=1.
//    - DONE -> IDLE unconditionally after one cycle.
//  - Latency: Start sampled at edge N gives Out_Valid=1 after edge N+1, with Out_Index=0.
//  - Handshake:
//    - A transfer occurs when Out_Valid && Out_Ready at a posedge.
//    - On a transfer, index increments.
//    - While Out_Valid=1 and Out_Ready=0, Out_Data/Out_Index/Out_Last hold stable.
//    - Out_Valid never drops without a transfer.
//    - Out_Valid=1 only in STREAM, so a full scan takes at least NUM_TILES cycles.
//  - Snapshot semantics: changes on Board_In after the capture edge do not affect the scan in progress.
//  - Start is ignored in STREAM and DONE; no queuing.
//    - Start held high through DONE begins a new scan at the edge after DONE.
//  - Accumulation, updated on each transfer:
//    - max = max(max, Out_Data), unsigned compare.
//    - empty += (Out_Data==0).
//    - Internal accumulators are not visible on the outputs.
//  - Result outputs:
//    - Max_Tile and Empty_Count load the final accumulator values (including the last tile) on entry to DONE.
//    - They hold until the next scan completes or Reset; a new scan does not clear them until its DONE.
//  - Done and Busy:
//    - Done=1 for exactly the DONE cycle.
//    - Busy=1 in STREAM and DONE, 0 in IDLE.
//  - Boundary values:
//    - All tiles zero gives Max_Tile=0 and Empty_Count=NUM_TILES (no overflow in CNT_W).
//    - All tiles nonzero gives Empty_Count=0.
//    - Index never wraps: Out_Last gates the exit from STREAM.
// TESTING
//  1. Board tile t = t+1, Ready=1, pulse Start -> Out_Index 0..15 on 16 consecutive cycles; Out_Data 1..16; Out_Last only at 15; Done 1 cycle later; Max_Tile=16, Empty_Count=0.
//  2. All-zero board -> Max_Tile=0, Empty_Count=16; tile 3=0x800, rest 0 -> Max_Tile=0x800, Empty_Count=15.
//  3. Ready toggles 1,0,0,1,... -> outputs stable while Ready=0; no tile skipped or duplicated; scan ends after exactly 16 transfers.
//  4. Rewrite Board_In to 0xFFF every cycle after the Start edge -> streamed values equal the pre-Start snapshot.
//  5. Reset asserted at tile 7 -> next cycle Out_Valid=0, Busy=0, Max_Tile=0, Empty_Count=0; a later Start scans from tile 0.
//  6. Start re-pulsed during STREAM -> ignored; Start held high -> back-to-back scans; prior Max_Tile holds until the new Done.

Source files
------------

// File: rtl/board_readback.sv
// Snapshot-and-stream reader for the tile register bank: captures every tile on Start,
// streams them out over valid/ready, and reports the largest tile and the empty-tile count.
module board_readback #(
  parameter int NUM_TILES = 16,
  parameter int DATA_W    = 12,
  parameter int IDX_W     = $clog2(NUM_TILES),
  parameter int CNT_W     = $clog2(NUM_TILES + 1)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [NUM_TILES*DATA_W-1:0] Board_In,
  input  logic                        Out_Ready,
  output logic                        Out_Valid,
  output logic [DATA_W-1:0]           Out_Data,
  output logic [IDX_W-1:0]            Out_Index,
  output logic                        Out_Last,
  output logic                        Busy,
  output logic                        Done,
  output logic [DATA_W-1:0]           Max_Tile,
  output logic [CNT_W-1:0]            Empty_Count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] count_zero(input logic [CNT_W-1:0]  cnt,
                                                  input logic [DATA_W-1:0] val);
    return (val == {DATA_W{1'b0}}) ? (cnt + CNT_W'(1)) : cnt;
  endfunction

  state_t                            state_r, state_s;
  logic [NUM_TILES-1:0][DATA_W-1:0]  shadow_r, shadow_s;
  logic [IDX_W-1:0]                  idx_r, idx_s, idx_inc_s;
  logic [DATA_W-1:0]                 max_acc_r, max_acc_s, max_upd_s;
  logic [CNT_W-1:0]                  empty_acc_r, empty_acc_s, empty_upd_s;
  logic                              valid_r, valid_s;
  logic [DATA_W-1:0]                 data_r, data_s;
  logic [IDX_W-1:0]                  index_r, index_s;
  logic                              last_r, last_s;
  logic                              busy_r, busy_s;
  logic                              done_r, done_s;
  logic [DATA_W-1:0]                 max_tile_r, max_tile_s;
  logic [CNT_W-1:0]                  empty_count_r, empty_count_s;

  // Accumulator values as they stand once the tile currently on the bus is accepted.
  assign idx_inc_s   = idx_r + IDX_W'(1);
  assign max_upd_s   = umax(max_acc_r, data_r);
  assign empty_upd_s = count_zero(empty_acc_r, data_r);

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s       = state_r;
    shadow_s      = shadow_r;
    idx_s         = idx_r;
    max_acc_s     = max_acc_r;
    empty_acc_s   = empty_acc_r;
    valid_s       = valid_r;
    data_s        = data_r;
    index_s       = index_r;
    last_s        = last_r;
    busy_s        = busy_r;
    done_s        = 1'b0;
    max_tile_s    = max_tile_r;
    empty_count_s = empty_count_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_s     = ST_STREAM;
          shadow_s    = Board_In;
          idx_s       = {IDX_W{1'b0}};
          max_acc_s   = {DATA_W{1'b0}};
          empty_acc_s = {CNT_W{1'b0}};
          busy_s      = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_STREAM: begin
        busy_s = 1'b1;
        if (!valid_r) begin
          // First STREAM cycle: present tile 0 from the freshly captured snapshot.
          valid_s = 1'b1;
          data_s  = shadow_r[idx_r];
          index_s = idx_r;
          last_s  = (idx_r == LAST_IDX);
        end else if (Out_Ready) begin
          max_acc_s   = max_upd_s;
          empty_acc_s = empty_upd_s;
          if (last_r) begin
            state_s       = ST_DONE;
            valid_s       = 1'b0;
            last_s        = 1'b0;
            done_s        = 1'b1;
            max_tile_s    = max_upd_s;
            empty_count_s = empty_upd_s;
          end else begin
            idx_s   = idx_inc_s;
            data_s  = shadow_r[idx_inc_s];
            index_s = idx_inc_s;
            last_s  = (idx_inc_s == LAST_IDX);
          end
        end else begin
          valid_s = valid_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, snapshot, accumulator and output registers with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      shadow_r      <= {(NUM_TILES*DATA_W){1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      max_acc_r     <= {DATA_W{1'b0}};
      empty_acc_r   <= {CNT_W{1'b0}};
      valid_r       <= 1'b0;
      data_r        <= {DATA_W{1'b0}};
      index_r       <= {IDX_W{1'b0}};
      last_r        <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      max_tile_r    <= {DATA_W{1'b0}};
      empty_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      shadow_r      <= shadow_s;
      idx_r         <= idx_s;
      max_acc_r     <= max_acc_s;
      empty_acc_r   <= empty_acc_s;
      valid_r       <= valid_s;
      data_r        <= data_s;
      index_r       <= index_s;
      last_r        <= last_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      max_tile_r    <= max_tile_s;
      empty_count_r <= empty_count_s;
    end
  end

  assign Out_Valid   = valid_r;
  assign Out_Data    = data_r;
  assign Out_Index   = index_r;
  assign Out_Last    = last_r;
  assign Busy        = busy_r;
  assign Done        = done_r;
  assign Max_Tile    = max_tile_r;
  assign Empty_Count = empty_count_r;

endmodule

// File: tb/tb_board_readback.sv
// Directed bench for board_readback: a scoreboard queue holds the tiles expected from each
// snapshot and is drained as transfers are observed; results are checked at each Done.
module tb_board_readback;

  localparam int NUM_TILES = 16;
  localparam int DATA_W    = 12;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 5;

  typedef logic [DATA_W-1:0] board_t [NUM_TILES];
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } exp_t;

  logic                        Clk = 1'b0;
  logic                        Reset = 1'b1;
  logic                        Start = 1'b0;
  logic [NUM_TILES*DATA_W-1:0] Board_In = '0;
  logic                        Out_Ready = 1'b0;
  logic                        Out_Valid;
  logic [DATA_W-1:0]           Out_Data;
  logic [IDX_W-1:0]            Out_Index;
  logic                        Out_Last;
  logic                        Busy;
  logic                        Done;
  logic [DATA_W-1:0]           Max_Tile;
  logic [CNT_W-1:0]            Empty_Count;

  exp_t              sb_q[$];
  int                compared = 0;
  int                mismatched = 0;
  logic [DATA_W-1:0] exp_max;
  logic [CNT_W-1:0]  exp_empty;

  board_readback #(
    .NUM_TILES(NUM_TILES), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Board_In(Board_In),
    .Out_Ready(Out_Ready), .Out_Valid(Out_Valid), .Out_Data(Out_Data),
    .Out_Index(Out_Index), .Out_Last(Out_Last), .Busy(Busy), .Done(Done),
    .Max_Tile(Max_Tile), .Empty_Count(Empty_Count)
  );

  always #5 Clk = ~Clk;

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a board and push its expected stream and results.
  task automatic load_expect(input board_t b);
    exp_max   = '0;
    exp_empty = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      Board_In[t*DATA_W +: DATA_W] = b[t];
      sb_q.push_back('{data: b[t], idx: IDX_W'(t), last: (t == NUM_TILES - 1)});
      if (b[t] > exp_max) exp_max = b[t];
      if (b[t] == '0) exp_empty = exp_empty + 5'd1;
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    cycle();
    Start = 1'b0;
  endtask

  // Run one scan to its Done: mode 0 = Ready always 1, mode 1 = Ready 1,0,0 repeating.
  task automatic stream(input int mode, input bit scramble, input bit repulse,
                        input int exp_first, input bit chk_prev,
                        input logic [DATA_W-1:0] prev_max);
    int   xfers = 0;
    int   first_k = -1;
    int   last_k = -1;
    bit   held = 1'b0;
    bit   done_seen = 1'b0;
    exp_t h = '0;
    exp_t e;
    for (int k = 0; k < 200 && !done_seen; k++) begin
      Out_Ready = (mode == 0) ? 1'b1 : 1'(k % 3 == 0);
      if (scramble) Board_In = {NUM_TILES{12'hFFF}};
      if (repulse) Start = 1'(k == 4);
      if (chk_prev && k == 8) check("max_hold_prev", Max_Tile, prev_max);
      if (held) begin
        check("hold_valid", Out_Valid, 1);
        check("hold_data", Out_Data, h.data);
        check("hold_index", Out_Index, h.idx);
        check("hold_last", Out_Last, h.last);
      end
      if (Out_Valid && Out_Ready) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        xfers++;
        check("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("xfer_data", Out_Data, e.data);
          check("xfer_index", Out_Index, e.idx);
          check("xfer_last", Out_Last, e.last);
        end
      end
      held = Out_Valid && !Out_Ready;
      h    = '{data: Out_Data, idx: Out_Index, last: Out_Last};
      if (Done) begin
        done_seen = 1'b1;
        check("xfer_count", xfers, NUM_TILES);
        check("sb_drained", sb_q.size(), 0);
        check("done_after_last", k - last_k, 1);
        check("done_busy", Busy, 1);
        check("done_valid", Out_Valid, 0);
        check("max_tile", Max_Tile, exp_max);
        check("empty_count", Empty_Count, exp_empty);
        if (exp_first >= 0) begin
          check("first_xfer_cycle", first_k, exp_first);
          check("consecutive_xfers", last_k - first_k, NUM_TILES - 1);
        end
      end
      cycle();
    end
    check("done_timeout", done_seen, 1);
    if (repulse) Start = 1'b0;
  endtask

  initial begin
    board_t            b1, bz, b3, b4, ba, bb;
    logic [DATA_W-1:0] prev;
    bit                found;

    for (int t = 0; t < NUM_TILES; t++) begin
      b1[t] = 12'(t + 1);
      bz[t] = 12'h000;
      b3[t] = (t == 3) ? 12'h800 : 12'h000;
      b4[t] = (t % 4 == 0) ? 12'h000 : 12'(t * 91 + 3);
      ba[t] = 12'(t * 7);
      bb[t] = 12'(12'h300 - 12'(t));
    end

    // Reset state
    cycle();
    cycle();
    check("rst_valid", Out_Valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_data", Out_Data, 0);
    check("rst_max", Max_Tile, 0);
    check("rst_empty", Empty_Count, 0);
    Reset = 1'b0;
    cycle();

    // Incrementing board, full-rate consumer, latency and Done pulse width
    load_expect(b1);
    pulse_start();
    check("lat_busy", Busy, 1);
    check("lat_valid", Out_Valid, 0);
    stream(0, 1'b0, 1'b0, 1, 1'b0, 12'h0);
    check("done_pulse_end", Done, 0);
    check("idle_busy", Busy, 0);

    // All-zero board, then a single 0x800 tile
    load_expect(bz);
    pulse_start();
    stream(0, 1'b0, 1'b0, 1, 1'b0, 12'h0);
    load_expect(b3);
    pulse_start();
    stream(0, 1'b0, 1'b0, 1, 1'b0, 12'h0);

    // Back-pressure with Ready 1,0,0 repeating
    load_expect(b4);
    pulse_start();
    stream(1, 1'b0, 1'b0, -1, 1'b0, 12'h0);

    // Board rewritten to 0xFFF after the capture edge
    load_expect(b4);
    pulse_start();
    stream(0, 1'b1, 1'b0, 1, 1'b0, 12'h0);

    // Reset while tile 7 is on the bus
    load_expect(b1);
    pulse_start();
    Out_Ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (Out_Valid && Out_Index == 4'd7) found = 1'b1;
      else cycle();
    end
    check("reset_reach_t7", found, 1);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    check("midrst_valid", Out_Valid, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_max", Max_Tile, 0);
    check("midrst_empty", Empty_Count, 0);
    sb_q.delete();
    cycle();
    load_expect(b1);
    pulse_start();
    stream(0, 1'b0, 1'b0, 1, 1'b0, 12'h0);

    // Start re-pulsed mid-scan is ignored, and nothing is queued afterwards
    load_expect(b3);
    pulse_start();
    stream(0, 1'b0, 1'b1, 1, 1'b0, 12'h0);
    for (int k = 0; k < 3; k++) begin
      check("no_queued_busy", Busy, 0);
      check("no_queued_valid", Out_Valid, 0);
      cycle();
    end

    // Start held high: back-to-back scans, prior result holds until the new Done
    load_expect(ba);
    Start = 1'b1;
    stream(0, 1'b0, 1'b0, 2, 1'b0, 12'h0);
    prev = exp_max;
    load_expect(bb);
    stream(0, 1'b0, 1'b0, 2, 1'b1, prev);
    Start = 1'b0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
